uart_tx_arbiter: RTL and testbench



---
 rtl/axil_pkg.sv | 13 +
 rtl/rr_select.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, UART character
// width and the default stall limit for the optional timeout.
package axil_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int UART_BYTE_W     = 8;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: scans from ptr+1 with wrap-around and
// returns the first requester as a one-hot vector plus its index.
module rr_select #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                       = 1'b1;
        gnt[(int'(ptr) + k) % N]  = 1'b1;
        idx                       = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the UART transmit byte stream.
// Optional stall timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import axil_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = UART_BYTE_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [NUM_REQ*DATA_W-1:0]   s_tdata,
  input  logic [NUM_REQ-1:0]          s_tvalid,
  input  logic [NUM_REQ-1:0]          s_tlast,
  output logic [NUM_REQ-1:0]          s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W != UART_BYTE_W || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter set");
  end

  arb_state_e          state;
  logic [IW-1:0]       ptr;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                out_free;
  logic                force_release;

  logic [DATA_W-1:0]   own_data_p0;
  logic                own_last_p0;
  logic                accept_p0;
  logic [DATA_W-1:0]   data_p1;
  logic                vld_p1;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_select (
    .req (s_tvalid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Stage p0: owner's beat is accepted when the output register is free or draining
  assign out_free    = !vld_p1 || m_tready;
  assign s_tready    = (state == GRANT && out_free) ? grant_oh : '0;
  assign own_data_p0 = s_tdata[grant_id*DATA_W +: DATA_W];
  assign own_last_p0 = s_tlast[grant_id];
  assign accept_p0   = |(s_tvalid & s_tready);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] stall_cnt;
  logic             own_valid;

  assign own_valid     = s_tvalid[grant_id];
  assign force_release = (state == GRANT) && !own_valid &&
                         (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Held at zero in IDLE, so every new grant starts from a cleared count
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= force_release;
      if (state == IDLE || accept_p0 || force_release)
        stall_cnt <= '0;
      else if (!own_valid)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign force_release = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Stage p1: output register and arbitration FSM
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      ptr      <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      grant_oh <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (accept_p0) begin
        data_p1 <= own_data_p0;
        vld_p1  <= 1'b1;
      end else if (m_tready) begin
        vld_p1  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            grant_id <= pick_idx;
            ptr      <= pick_idx;
            grant_oh <= pick_gnt;
          end
        end
        GRANT: begin
          if ((accept_p0 && own_last_p0) || force_release)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_tdata  = data_p1;
  assign m_tvalid = vld_p1;
  assign busy     = (state == GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with four requesters.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TCYC = 16;

  logic               aclk = 1'b0;
  logic               areset;
  logic [NREQ*DW-1:0] s_tdata;
  logic [NREQ-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]      m_tdata;
  logic               m_tvalid, m_tready;
  logic [1:0]         grant_id;
  logic               busy, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [8:0] src_q [NREQ][$];
  logic [7:0] exp_q [$];
  int         grant_log [$];
  int         gap_log [$];
  int         idle_run;
  logic       prev_busy;
  logic [NREQ-1:0] acc;

  always #5 aclk = ~aclk;

  uart_tx_arbiter #(
    .NUM_REQ     (NREQ),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic drive();
    logic [8:0] beat;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        beat = src_q[i][0];
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = beat[7:0];
        s_tlast[i]           = beat[8];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int i, input logic last, input logic [7:0] data);
    src_q[i].push_back({last, data});
    drive();
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: compare the output handshake, advance sources, log grants.
  task automatic step();
    logic [7:0] e;
    @(negedge aclk);
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_byte got %h exp none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        if (m_tdata !== e) begin
          errors++;
          $display("FAIL out_byte got %h exp %h", m_tdata, e);
        end
      end
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_id));
      gap_log.push_back(idle_run);
      idle_run = 0;
    end else if (!busy) begin
      idle_run++;
    end
    prev_busy = busy;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    idle_run  = 0;
    prev_busy = 1'b0;
  endtask

  task automatic reset_dut();
    areset   = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    clear_logs();
  endtask

  task automatic run_drain(input int max_cyc);
    int n = 0;
    while ((pending() || exp_q.size() > 0 || m_tvalid) && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (pending() || exp_q.size() > 0 || m_tvalid) begin
      errors++;
      $display("FAIL drain got %0d bytes left exp 0 within %0d cycles", exp_q.size(), max_cyc);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({s_tready, m_tvalid, m_tdata, grant_id, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {s_tready, m_tvalid, m_tdata, grant_id, busy, timeout_err});
    end
  endtask

  task automatic test_basic();
    reset_dut();
    push_src(0, 1'b0, 8'h41);
    push_src(0, 1'b1, 8'h42);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    step();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL basic_grant got busy=%b id=%0d exp busy=1 id=0", busy, grant_id);
    end
    step();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h41) begin
      errors++;
      $display("FAIL basic_first got %b/%h exp 1/41", m_tvalid, m_tdata);
    end
    step();
    checks++;
    if (m_tdata !== 8'h42 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got %h busy=%b exp 42 busy=0", m_tdata, busy);
    end
    run_drain(20);
  endtask

  task automatic test_two_frames();
    reset_dut();
    for (int b = 0; b < 3; b++) begin
      push_src(0, b == 2, 8'h10 + 8'(b));
      push_src(1, b == 2, 8'h20 + 8'(b));
    end
    for (int b = 0; b < 3; b++) exp_q.push_back(8'h10 + 8'(b));
    for (int b = 0; b < 3; b++) exp_q.push_back(8'h20 + 8'(b));
    run_drain(40);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      errors++;
      $display("FAIL two_frames_order got %0d grants first=%0d exp 2 grants 0,1",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  task automatic test_stall();
    reset_dut();
    for (int b = 0; b < 5; b++) begin
      push_src(0, b == 4, 8'h30 + 8'(b));
      exp_q.push_back(8'h30 + 8'(b));
    end
    repeat (3) step();
    m_tready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (s_tready !== '0 || m_tvalid !== 1'b1 || m_tdata !== 8'h31) begin
        errors++;
        $display("FAIL stall_hold got rdy=%b vld=%b data=%h exp 0000/1/31", s_tready, m_tvalid, m_tdata);
      end
      step();
    end
    m_tready = 1'b1;
    run_drain(30);
  endtask

  task automatic test_rotation();
    int bad;
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) begin
        push_src(i, 1'b1, 8'h60 + 8'(r*4 + i));
        exp_q.push_back(8'h60 + 8'(r*4 + i));
      end
    run_drain(60);
    bad = 0;
    for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != k % NREQ) bad++;
    checks++;
    if (grant_log.size() != 8 || bad != 0) begin
      errors++;
      $display("FAIL rotation_order got %0d grants %0d out of order exp 8 grants 0 out of order",
               grant_log.size(), bad);
    end
    bad = 0;
    for (int k = 1; k < gap_log.size(); k++) if (gap_log[k] != 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rotation_idle_gap got %0d gaps not 1 exp 0", bad);
    end
    checks++;
    if (grant_id !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL grant_id_hold got id=%0d busy=%b exp id=3 busy=0", grant_id, busy);
    end
  endtask

  task automatic test_reset_midframe();
    reset_dut();
    for (int b = 0; b < 4; b++) begin
      push_src(0, b == 3, 8'h70 + 8'(b));
      exp_q.push_back(8'h70 + 8'(b));
    end
    repeat (3) step();
    areset = 1'b1;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tdata, grant_id, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL midframe_reset got %h exp 0",
               {s_tready, m_tvalid, m_tdata, grant_id, busy, timeout_err});
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    clear_logs();
    push_src(0, 1'b1, 8'h7A);
    push_src(1, 1'b1, 8'h7B);
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h7B);
    run_drain(30);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL midframe_regrant got %0d grants first=%0d exp first=0",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    reset_dut();
    push_src(0, 1'b0, 8'h80);
    push_src(1, 1'b1, 8'h81);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    repeat (2) step();
    for (int k = 0; k < TCYC - 1; k++) begin
      step();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early cycle %0d got err=%b busy=%b exp 0/1", k, timeout_err, busy);
      end
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got err=%b busy=%b exp 1/0", timeout_err, busy);
    end
    step();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL timeout_regrant got err=%b busy=%b id=%0d exp 0/1/1", timeout_err, busy, grant_id);
    end
    run_drain(30);
  endtask
`else
  task automatic test_hold();
    reset_dut();
    push_src(0, 1'b0, 8'h90);
    push_src(1, 1'b1, 8'h95);
    exp_q.push_back(8'h90);
    repeat (2) step();
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL hold_grant cycle %0d got err=%b busy=%b id=%0d exp 0/1/0",
                 k, timeout_err, busy, grant_id);
      end
    end
    push_src(0, 1'b1, 8'h91);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'h95);
    run_drain(30);
  endtask
`endif

  initial begin
    areset   = 1'b1;
    m_tready = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    clear_logs();
    #12;
    test_reset();
    test_basic();
    test_two_frames();
    test_stall();
    test_rotation();
    test_reset_midframe();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
